// File: rtl/keypad_scanner_if.sv
// Board-side bundle of the keypad scanner: matrix row/column lines plus the NumIn/Flag key stream.
interface keypad_scanner_if;
  logic [3:0] Col;
  logic [3:0] Row;
  logic [3:0] NumIn;
  logic       Flag;

  // master: the scanner itself; slave: keypad matrix and the consuming FSM
  modport master (input Col, output Row, output NumIn, output Flag);
  modport slave  (output Col, input Row, input NumIn, input Flag);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row scan, scan-level debounce, multi-key rejection, key encoding.
// Optional auto-repeat of a held key is built when KEYPAD_REPEAT_EN is defined.
module keypad_scanner #(
  parameter int SCAN_DIV     = 250,
  parameter int DEBOUNCE     = 4,
  parameter int REPEAT_SCANS = 100
) (
  input  logic             Clk1,
  input  logic             Rst_n,
  keypad_scanner_if.master kp
);
  localparam int              DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]      DEB_TARGET = 4'(DEBOUNCE);

  if (SCAN_DIV < 1 || DEBOUNCE < 1 || DEBOUNCE > 15 || REPEAT_SCANS < 1) begin : g_param_check
    $error("keypad_scanner: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, HELD, REP_LOW} state_t;
  typedef enum logic [1:0] {RES_EMPTY, RES_SINGLE, RES_MULTI} result_t;

  function automatic logic [3:0] key_code(input logic [3:0] idx);
    case (idx)
      4'd0:    key_code = 4'd1;
      4'd1:    key_code = 4'd2;
      4'd2:    key_code = 4'd3;
      4'd3:    key_code = 4'd10;
      4'd4:    key_code = 4'd4;
      4'd5:    key_code = 4'd5;
      4'd6:    key_code = 4'd6;
      4'd7:    key_code = 4'd11;
      4'd8:    key_code = 4'd7;
      4'd9:    key_code = 4'd8;
      4'd10:   key_code = 4'd9;
      4'd11:   key_code = 4'd12;
      4'd12:   key_code = 4'd13;
      4'd13:   key_code = 4'd0;
      4'd14:   key_code = 4'd14;
      default: key_code = 4'd15;
    endcase
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    sat_inc = (v == 4'hF) ? v : v + 4'd1;
  endfunction

  logic [3:0]       col_meta_reg, col_sync_reg;
  logic [DIV_W-1:0] div_cnt_reg;
  logic [1:0]       slot_reg;
  logic [3:0]       row_reg;
  logic [1:0]       zero_cnt_reg;   // zero bits seen so far this scan, saturating at 2
  logic [3:0]       idx_reg;
  logic             scan_done_reg;
  result_t          result_reg;
  logic [3:0]       code_reg;

  logic [2:0] slot_zeros;
  logic [1:0] slot_col;
  logic [2:0] total_zeros;
  logic [1:0] zero_cnt_next;
  logic [3:0] idx_next;
  logic       slot_end;

  always_comb begin
    slot_zeros = 3'd0;
    slot_col   = 2'd0;
    for (int c = 0; c < 4; c++) begin
      if (!col_sync_reg[c]) begin
        slot_zeros = slot_zeros + 3'd1;
        slot_col   = 2'(c);
      end
    end
  end

  assign slot_end      = (div_cnt_reg == DIV_LAST);
  assign total_zeros   = {1'b0, zero_cnt_reg} + slot_zeros;
  assign zero_cnt_next = (total_zeros >= 3'd2) ? 2'd2 : total_zeros[1:0];
  assign idx_next      = (slot_zeros == 3'd1) ? {slot_reg, slot_col} : idx_reg;

  always_ff @(posedge Clk1 or negedge Rst_n) begin
    if (!Rst_n) begin
      col_meta_reg  <= 4'hF;
      col_sync_reg  <= 4'hF;
      div_cnt_reg   <= '0;
      slot_reg      <= 2'd0;
      row_reg       <= 4'b1110;
      zero_cnt_reg  <= 2'd0;
      idx_reg       <= 4'd0;
      scan_done_reg <= 1'b0;
      result_reg    <= RES_EMPTY;
      code_reg      <= 4'd0;
    end else begin
      col_meta_reg  <= kp.Col;
      col_sync_reg  <= col_meta_reg;
      scan_done_reg <= 1'b0;
      if (slot_end) begin
        div_cnt_reg <= '0;
        slot_reg    <= slot_reg + 2'd1;
        row_reg     <= {row_reg[2:0], row_reg[3]};
        if (slot_reg == 2'd3) begin
          // Scan closes: publish the verdict; the FSM acts on it next cycle
          scan_done_reg <= 1'b1;
          result_reg    <= (total_zeros == 3'd0) ? RES_EMPTY :
                           (total_zeros == 3'd1) ? RES_SINGLE : RES_MULTI;
          code_reg      <= key_code(idx_next);
          zero_cnt_reg  <= 2'd0;
          idx_reg       <= 4'd0;
        end else begin
          zero_cnt_reg <= zero_cnt_next;
          idx_reg      <= idx_next;
        end
      end else begin
        div_cnt_reg <= div_cnt_reg + 1'b1;
      end
    end
  end

  state_t     state_reg;
  logic [3:0] match_cnt_reg, rel_cnt_reg, cand_reg;
  logic [3:0] num_reg;
  logic       flag_reg;
  logic [3:0] match_next, rel_next;
  logic       release_done;

  assign match_next   = (result_reg == RES_SINGLE && code_reg == cand_reg && match_cnt_reg != 4'd0)
                        ? sat_inc(match_cnt_reg) : 4'd1;
  assign rel_next     = (result_reg == RES_EMPTY) ? sat_inc(rel_cnt_reg) : 4'd0;
  assign release_done = (result_reg == RES_EMPTY) && (rel_next >= DEB_TARGET);

`ifdef KEYPAD_REPEAT_EN
  localparam int               HOLD_W      = $clog2(REPEAT_SCANS + 1);
  localparam logic [HOLD_W-1:0] HOLD_TARGET = HOLD_W'(REPEAT_SCANS);
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic [HOLD_W-1:0] hold_next;
  assign hold_next = hold_cnt_reg + 1'b1;
`endif

  always_ff @(posedge Clk1 or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg     <= IDLE;
      match_cnt_reg <= 4'd0;
      rel_cnt_reg   <= 4'd0;
      cand_reg      <= 4'd0;
      num_reg       <= 4'd0;
      flag_reg      <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      hold_cnt_reg  <= '0;
`endif
    end else if (scan_done_reg) begin
      case (state_reg)
        IDLE: begin
          rel_cnt_reg <= 4'd0;
          if (result_reg == RES_SINGLE) begin
            cand_reg <= code_reg;
            if (match_next >= DEB_TARGET) begin
              num_reg       <= code_reg;
              flag_reg      <= 1'b1;
              state_reg     <= HELD;
              match_cnt_reg <= 4'd0;
`ifdef KEYPAD_REPEAT_EN
              hold_cnt_reg  <= '0;
`endif
            end else begin
              match_cnt_reg <= match_next;
            end
          end else begin
            match_cnt_reg <= 4'd0;
          end
        end
        HELD: begin
          // Any other key while held only resets the release count; NumIn stays put
          rel_cnt_reg <= release_done ? 4'd0 : rel_next;
          if (release_done) begin
            flag_reg  <= 1'b0;
            state_reg <= IDLE;
          end
`ifdef KEYPAD_REPEAT_EN
          else if (hold_next == HOLD_TARGET) begin
            flag_reg     <= 1'b0;
            state_reg    <= REP_LOW;
            hold_cnt_reg <= '0;
          end else begin
            hold_cnt_reg <= hold_next;
          end
`endif
        end
`ifdef KEYPAD_REPEAT_EN
        REP_LOW: begin
          rel_cnt_reg <= release_done ? 4'd0 : rel_next;
          if (release_done) begin
            state_reg <= IDLE;
          end else begin
            flag_reg     <= 1'b1;
            state_reg    <= HELD;
            hold_cnt_reg <= '0;
          end
        end
`endif
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign kp.Row   = row_reg;
  assign kp.NumIn = num_reg;
  assign kp.Flag  = flag_reg;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 keypad matrix model.
module tb_keypad_scanner;
  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE     = 2;
  localparam int REPEAT_SCANS = 5;
  localparam int SCAN         = 4 * SCAN_DIV;
  localparam int LAT          = (DEBOUNCE + 1) * SCAN + 3;

  logic        Clk1 = 1'b0;
  logic        Rst_n = 1'b0;
  logic [15:0] key_down = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  keypad_scanner_if kp();

  keypad_scanner #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE), .REPEAT_SCANS(REPEAT_SCANS)
  ) dut (
    .Clk1 (Clk1),
    .Rst_n(Rst_n),
    .kp   (kp)
  );

  always #5 Clk1 = ~Clk1;

  // Pressed key (r,c) pulls column c low while row r is driven low
  always_comb begin
    kp.Col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_down[4*r+c] && !kp.Row[r]) kp.Col[c] = 1'b0;
  end

  // NumIn may only change on the cycle Flag rises
  logic [3:0] mon_num;
  logic       mon_flag;
  logic       mon_valid = 1'b0;
  always @(posedge Clk1) begin
    #1;
    if (Rst_n && mon_valid && kp.NumIn !== mon_num) begin
      n_cmp++;
      if (!(kp.Flag === 1'b1 && mon_flag === 1'b0)) begin
        n_bad++;
        $display("FAIL numin_stable: NumIn %0d -> %0d with Flag %b -> %b", mon_num, kp.NumIn, mon_flag, kp.Flag);
      end
    end
    mon_valid = Rst_n;
    mon_num   = kp.NumIn;
    mon_flag  = kp.Flag;
  end

  task automatic tick();
    @(posedge Clk1);
    #1;
  endtask

  task automatic wait_flag(input logic level, input int limit, output int cycles);
    cycles = limit + 1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (kp.Flag === level) begin
        cycles = i;
        return;
      end
    end
  endtask

  // Returns just after the edge that starts a new scan (Row back to slot 0)
  task automatic align_scan();
    logic [3:0] prev;
    prev = kp.Row;
    for (int i = 0; i < 2 * SCAN; i++) begin
      tick();
      if (kp.Row === 4'b1110 && prev === 4'b0111) return;
      prev = kp.Row;
    end
    n_cmp++; n_bad++;
    $display("FAIL align_scan: Row did not return to slot 0 within %0d cycles", 2 * SCAN);
  endtask

  task automatic idle_gap();
    repeat (2 * SCAN) tick();
  endtask

  task automatic test_reset();
    int cyc;
    Rst_n = 1'b0;
    repeat (3) tick();
    n_cmp++; if (kp.Row !== 4'b1110) begin n_bad++; $display("FAIL reset_row: got %b expected 1110", kp.Row); end
    n_cmp++; if (kp.Flag !== 1'b0) begin n_bad++; $display("FAIL reset_flag: got %b expected 0", kp.Flag); end
    n_cmp++; if (kp.NumIn !== 4'd0) begin n_bad++; $display("FAIL reset_numin: got %0d expected 0", kp.NumIn); end
    Rst_n = 1'b1;
    key_down = 16'h0004;            // row 0 col 2 -> code 3
    wait_flag(1'b1, LAT, cyc);
    n_cmp++; if (cyc > LAT) begin n_bad++; $display("FAIL reset_first_press: latency %0d exceeds %0d", cyc, LAT); end
    n_cmp++; if (kp.NumIn !== 4'd3) begin n_bad++; $display("FAIL reset_first_code: got %0d expected 3", kp.NumIn); end
    tick();
    #2 Rst_n = 1'b0;
    #1;
    n_cmp++; if (kp.Row !== 4'b1110) begin n_bad++; $display("FAIL midreset_row: got %b expected 1110", kp.Row); end
    n_cmp++; if (kp.Flag !== 1'b0) begin n_bad++; $display("FAIL midreset_flag: got %b expected 0", kp.Flag); end
    n_cmp++; if (kp.NumIn !== 4'd0) begin n_bad++; $display("FAIL midreset_numin: got %0d expected 0", kp.NumIn); end
    tick();
    tick();
    Rst_n = 1'b1;                   // key still held through reset
    wait_flag(1'b1, LAT, cyc);
    n_cmp++; if (cyc <= 2 * SCAN) begin n_bad++; $display("FAIL reset_no_early_rise: Flag rose after %0d cycles, required > %0d", cyc, 2 * SCAN); end
    n_cmp++; if (cyc > LAT) begin n_bad++; $display("FAIL reset_repress: latency %0d exceeds %0d", cyc, LAT); end
    key_down = '0;
    wait_flag(1'b0, LAT, cyc);
    n_cmp++; if (cyc > LAT) begin n_bad++; $display("FAIL reset_release: latency %0d exceeds %0d", cyc, LAT); end
    idle_gap();
  endtask

  task automatic test_press_release();
    int cyc;
    int bad;
    key_down = 16'h0800;            // row 2 col 3 -> code 12
    wait_flag(1'b1, LAT, cyc);
    n_cmp++; if (cyc > LAT || cyc < (DEBOUNCE - 1) * SCAN) begin n_bad++; $display("FAIL press_latency: got %0d cycles, required %0d..%0d", cyc, (DEBOUNCE - 1) * SCAN, LAT); end
    n_cmp++; if (kp.NumIn !== 4'd12) begin n_bad++; $display("FAIL press_code: got %0d expected 12", kp.NumIn); end
    bad = 0;
    for (int i = 0; i < 4 * SCAN; i++) begin
      tick();
      if (kp.Flag !== 1'b1 || kp.NumIn !== 4'd12) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL press_hold: %0d cycles off, expected 0 (Flag=1 NumIn=12)", bad); end
    key_down = '0;
    wait_flag(1'b0, LAT, cyc);
    n_cmp++; if (cyc > LAT || cyc < (DEBOUNCE - 1) * SCAN) begin n_bad++; $display("FAIL release_latency: got %0d cycles, required %0d..%0d", cyc, (DEBOUNCE - 1) * SCAN, LAT); end
    idle_gap();
    n_cmp++; if (kp.NumIn !== 4'd12) begin n_bad++; $display("FAIL release_code: got %0d expected 12", kp.NumIn); end
  endtask

  task automatic test_chatter();
    int cyc;
    int bad;
    for (int t = 0; t < (5 * SCAN) / 3; t++) begin
      key_down = key_down ^ 16'h0002;   // row 0 col 1 -> code 2, bouncing
      repeat (3) tick();
    end
    key_down = 16'h0002;
    wait_flag(1'b1, LAT, cyc);
    n_cmp++; if (cyc > LAT) begin n_bad++; $display("FAIL chatter_settle: latency %0d exceeds %0d", cyc, LAT); end
    n_cmp++; if (kp.NumIn !== 4'd2) begin n_bad++; $display("FAIL chatter_code: got %0d expected 2", kp.NumIn); end
    key_down = '0;
    wait_flag(1'b0, LAT, cyc);
    n_cmp++; if (cyc > LAT) begin n_bad++; $display("FAIL chatter_release: latency %0d exceeds %0d", cyc, LAT); end
    idle_gap();
    // Press present only on alternate scans: never two matching scans in a row
    align_scan();
    bad = 0;
    for (int s = 0; s < 6; s++) begin
      key_down = (s % 2 == 0) ? 16'h0002 : 16'h0000;
      for (int i = 0; i < SCAN; i++) begin
        tick();
        if (kp.Flag !== 1'b0) bad++;
      end
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL chatter_alternate: Flag high %0d cycles, expected 0", bad); end
    key_down = 16'h0002;
    wait_flag(1'b1, LAT, cyc);
    n_cmp++; if (cyc > LAT) begin n_bad++; $display("FAIL chatter_clean_press: latency %0d exceeds %0d", cyc, LAT); end
    key_down = '0;
    wait_flag(1'b0, LAT, cyc);
    idle_gap();
  endtask

  task automatic test_multi_key();
    int bad;
    key_down = 16'h0011;            // rows 0 and 1, col 0
    bad = 0;
    for (int i = 0; i < 10 * SCAN; i++) begin
      tick();
      if (kp.Flag !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL multi_flag: Flag high %0d cycles, expected 0", bad); end
    n_cmp++; if (kp.NumIn !== 4'd2) begin n_bad++; $display("FAIL multi_numin: got %0d expected 2", kp.NumIn); end
    key_down = '0;
    bad = 0;
    for (int i = 0; i < 2 * SCAN; i++) begin
      tick();
      if (kp.Flag !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL multi_after: Flag high %0d cycles, expected 0", bad); end
  endtask

  task automatic test_key_swap();
    int cyc;
    int bad;
    key_down = 16'h2000;            // row 3 col 1 -> code 0
    wait_flag(1'b1, LAT, cyc);
    n_cmp++; if (cyc > LAT) begin n_bad++; $display("FAIL swap_press: latency %0d exceeds %0d", cyc, LAT); end
    n_cmp++; if (kp.NumIn !== 4'd0) begin n_bad++; $display("FAIL swap_code: got %0d expected 0", kp.NumIn); end
    key_down = 16'h0080;            // row 1 col 3 (code 11) without release
    bad = 0;
    for (int i = 0; i < 4 * SCAN; i++) begin
      tick();
      if (kp.Flag !== 1'b1 || kp.NumIn !== 4'd0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL swap_hold: %0d cycles off, expected 0 (Flag=1 NumIn=0)", bad); end
    key_down = '0;
    wait_flag(1'b0, LAT, cyc);
    n_cmp++; if (cyc > LAT) begin n_bad++; $display("FAIL swap_release: latency %0d exceeds %0d", cyc, LAT); end
    n_cmp++; if (kp.NumIn !== 4'd0) begin n_bad++; $display("FAIL swap_final_code: got %0d expected 0", kp.NumIn); end
    idle_gap();
  endtask

  // Hold row 0 col 3 (code 10) for 14 scans and count low pulses bracketed by rises
  task automatic test_repeat();
`ifdef KEYPAD_REPEAT_EN
    localparam int EXP_PULSES = 2;
`else
    localparam int EXP_PULSES = 0;
`endif
    logic prev;
    int   fall_at;
    int   pulses;
    int   code_bad;
    logic rose;
    align_scan();
    key_down = 16'h0008;
    prev = kp.Flag; fall_at = -1; pulses = 0; code_bad = 0; rose = 1'b0;
    for (int i = 1; i <= 17 * SCAN + 5; i++) begin
      tick();
      if (i == 14 * SCAN) key_down = '0;
      if (kp.Flag === 1'b1 && prev === 1'b0) begin
        if (rose) begin
          pulses++;
          n_cmp++;
          if (i - fall_at != SCAN) begin n_bad++; $display("FAIL repeat_low_len: got %0d cycles expected %0d", i - fall_at, SCAN); end
        end
        rose = 1'b1;
      end
      if (kp.Flag === 1'b0 && prev === 1'b1) fall_at = i;
      if (rose && kp.NumIn !== 4'd10) code_bad++;
      prev = kp.Flag;
    end
    n_cmp++; if (!rose) begin n_bad++; $display("FAIL repeat_rise: Flag never rose, expected rise"); end
    n_cmp++; if (pulses != EXP_PULSES) begin n_bad++; $display("FAIL repeat_pulses: got %0d expected %0d", pulses, EXP_PULSES); end
    n_cmp++; if (code_bad != 0) begin n_bad++; $display("FAIL repeat_code: NumIn off 10 for %0d cycles, expected 0", code_bad); end
    n_cmp++; if (kp.Flag !== 1'b0) begin n_bad++; $display("FAIL repeat_release: got Flag %b expected 0", kp.Flag); end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_chatter();
    test_multi_key();
    test_key_swap();
    test_repeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
